// File: rtl/dmem_resp_if.sv
// ---------------------------------------------------------------------------
// dmem_resp_if
//
// Request/response bundle between the multicycle control FSM (master) and
// the data-memory responder (slave).
//
// Signals:
//   REQ    master->slave  request strobe, sampled only while the slave is idle
//   WE     master->slave  1 = store, 0 = load
//   SWAP   master->slave  1 = atomic swap, overrides WE
//   ADDR   master->slave  word address, AW bits
//   WDATA  master->slave  store/swap data, DW bits
//   BE     master->slave  byte enables, DW/8 bits (only with DMEM_BYTE_EN)
//   RDATA  slave->master  load/swap result, valid with ACK, held to next ACK
//   ACK    slave->master  one-cycle completion pulse
//   BUSY   slave->master  transaction in flight, through the ACK cycle
//   ERR    slave->master  with ACK: address out of range
//
// Optional feature macro: DMEM_BYTE_EN adds the BE signal.
// ---------------------------------------------------------------------------
interface dmem_resp_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic          REQ;
   logic          WE;
   logic          SWAP;
   logic [AW-1:0] ADDR;
   logic [DW-1:0] WDATA;
   logic [DW-1:0] RDATA;
   logic          ACK;
   logic          BUSY;
   logic          ERR;

`ifdef DMEM_BYTE_EN
   logic [DW/8-1:0] BE;

   modport master (
      output REQ, WE, SWAP, ADDR, WDATA, BE,
      input  RDATA, ACK, BUSY, ERR
   );

   modport slave (
      input  REQ, WE, SWAP, ADDR, WDATA, BE,
      output RDATA, ACK, BUSY, ERR
   );
`else
   modport master (
      output REQ, WE, SWAP, ADDR, WDATA,
      input  RDATA, ACK, BUSY, ERR
   );

   modport slave (
      input  REQ, WE, SWAP, ADDR, WDATA,
      output RDATA, ACK, BUSY, ERR
   );
`endif
endinterface

// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp
//
// Memory-side end of the load/store/swap request interface. Accepts one
// request at a time, waits WAIT_CYC cycles, performs the access on the
// word-addressed storage array and returns a one-cycle ACK with read data.
//
// Parameters:
//   DW        data word width in bits
//   AW        word address width in bits
//   DEPTH     number of implemented words (DEPTH <= 2**AW)
//   WAIT_CYC  wait states between acceptance and access (0..15)
//
// Ports:
//   CLK   system clock, rising edge
//   RST   synchronous active-high reset
//   bus   dmem_resp_if.slave: REQ/WE/SWAP/ADDR/WDATA(/BE) in,
//         RDATA/ACK/BUSY/ERR out (all outputs registered)
//
// Optional feature macro: DMEM_BYTE_EN
//   Defined   : stores and swaps write only the bytes selected by BE,
//               latched at acceptance; a swap still returns the full word.
//   Undefined : every write is full-word and there is no BE signal.
//
// Timing: REQ sampled at edge N gives ACK in the cycle after edge
// N+WAIT_CYC+1. The ACK cycle itself is spent in IDLE, so acceptance is
// blocked while ACK is high; the earliest next acceptance is the edge
// after the ACK cycle.
// ---------------------------------------------------------------------------
module dmem_resp #(
   parameter int DW       = 32,
   parameter int AW       = 8,
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 2
) (
   input  logic       CLK,
   input  logic       RST,
   dmem_resp_if.slave bus
);

   localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);
`ifdef DMEM_BYTE_EN
   localparam int          NB        = DW / 8;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    wait_cnt;

   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          we_q;
   logic          swap_q;
`ifdef DMEM_BYTE_EN
   logic [NB-1:0] be_q;
`endif

   logic [DW-1:0] rdata_q;
   logic          ack_q;
   logic          busy_q;
   logic          err_q;

   logic [DW-1:0] mem [DEPTH];

   logic          in_range;
   logic [IW-1:0] idx;
   logic          mem_wr;

   // Addresses at or beyond DEPTH never touch the array; idx is only
   // meaningful when in_range is set.
   assign in_range = ({1'b0, addr_q} < DEPTH_W);
   assign idx      = addr_q[IW-1:0];

   // A reset coinciding with the access edge must suppress the write,
   // so RST is folded into the write enable of the unreset array.
   assign mem_wr   = !RST && (state == S_ACCESS) && in_range && (we_q || swap_q);

   assign bus.RDATA = rdata_q;
   assign bus.ACK   = ack_q;
   assign bus.BUSY  = busy_q;
   assign bus.ERR   = err_q;

   // Control FSM with registered outputs. ACK and ERR default low every
   // cycle so they pulse for exactly one cycle; BUSY is set on acceptance
   // and cleared by the first IDLE edge after the ACK cycle. The read of
   // mem in ACCESS samples the old word at the same edge the array block
   // writes the new one, giving read-before-write swap semantics.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         swap_q   <= 1'b0;
`ifdef DMEM_BYTE_EN
         be_q     <= '0;
`endif
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (bus.REQ && !ack_q) begin
                  addr_q   <= bus.ADDR;
                  wdata_q  <= bus.WDATA;
                  we_q     <= bus.WE;
                  swap_q   <= bus.SWAP;
`ifdef DMEM_BYTE_EN
                  be_q     <= bus.BE;
`endif
                  wait_cnt <= WAIT_INIT;
                  busy_q   <= 1'b1;
                  state    <= (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
               end
            end

            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) begin
                  state <= S_ACCESS;
               end
            end

            S_ACCESS: begin
               ack_q <= 1'b1;
               state <= S_IDLE;
               if (!in_range) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else if (swap_q || !we_q) begin
                  rdata_q <= mem[idx];
               end
            end

            default: begin
               state    <= S_IDLE;
               wait_cnt <= '0;
               rdata_q  <= '0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Storage array, deliberately not reset.
   always_ff @(posedge CLK) begin
      if (mem_wr) begin
`ifdef DMEM_BYTE_EN
         for (int b = 0; b < NB; b++) begin
            if (be_q[b]) begin
               mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
`else
         mem[idx] <= wdata_q;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

   localparam int DW       = 32;
   localparam int AW       = 8;
   localparam int DEPTH    = 128;
   localparam int WAIT_CYC = 2;
   localparam int LAT      = WAIT_CYC + 1;
`ifdef DMEM_BYTE_EN
   localparam bit BE_BUILD = 1'b1;
`else
   localparam bit BE_BUILD = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST;

   dmem_resp_if #(.DW(DW), .AW(AW)) bus ();

   dmem_resp #(
      .DW       (DW),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .WAIT_CYC (WAIT_CYC)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: plain word array plus the last value RDATA was given.
   logic [31:0] model_mem [256];
   logic [31:0] model_rdata;

   task automatic model_op(input logic we, input logic sw, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           output logic [31:0] exp_rd, output logic exp_err);
      logic [3:0]  mask;
      logic [31:0] old;
      mask    = be | {4{~BE_BUILD}};
      exp_err = 1'b0;
      if (int'(addr) >= DEPTH) begin
         exp_err     = 1'b1;
         model_rdata = 32'h0;
      end else begin
         old = model_mem[addr];
         if (sw || we) begin
            for (int b = 0; b < 4; b++) begin
               if (mask[b]) model_mem[addr][b*8 +: 8] = wd[b*8 +: 8];
            end
         end
         if (sw || !we) model_rdata = old;
      end
      exp_rd = model_rdata;
   endtask

   // One request: REQ for one cycle, inputs scrambled after acceptance,
   // then wait (bounded) for ACK. lat counts edges after the accept edge.
   task automatic apply_stimulus(input logic we, input logic sw, input logic [7:0] addr,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 output logic [31:0] rd, output logic er,
                                 output int lat, output logic got_ack);
      rd      = '0;
      er      = 1'b0;
      lat     = 0;
      got_ack = 1'b0;
      @(negedge CLK);
      bus.REQ   = 1'b1;
      bus.WE    = we;
      bus.SWAP  = sw;
      bus.ADDR  = addr;
      bus.WDATA = wd;
`ifdef DMEM_BYTE_EN
      bus.BE    = be;
`endif
      @(posedge CLK);
      @(negedge CLK);
      bus.REQ   = 1'b0;
      bus.WE    = 1'($urandom);
      bus.SWAP  = 1'($urandom);
      bus.ADDR  = 8'($urandom);
      bus.WDATA = $urandom;
`ifdef DMEM_BYTE_EN
      bus.BE    = 4'($urandom);
`endif
      while (!got_ack && lat < 40) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
         if (bus.ACK === 1'b1) begin
            got_ack = 1'b1;
            rd      = bus.RDATA;
            er      = bus.ERR;
         end
      end
   endtask

   task automatic test_reset();
      RST       = 1'b1;
      bus.REQ   = 1'b1;
      bus.WE    = 1'b1;
      bus.SWAP  = 1'b0;
      bus.ADDR  = 8'h00;
      bus.WDATA = 32'h0;
`ifdef DMEM_BYTE_EN
      bus.BE    = 4'hF;
`endif
      model_rdata = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      tests_run++;
      if (bus.ACK !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack: got %b want 0", bus.ACK); end
      tests_run++;
      if (bus.BUSY !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", bus.BUSY); end
      tests_run++;
      if (bus.ERR !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b want 0", bus.ERR); end
      tests_run++;
      if (bus.RDATA !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.RDATA); end
      bus.REQ = 1'b0;
      RST     = 1'b0;
   endtask

   task automatic test_fill();
      logic [31:0] rd, exp_rd, wd;
      logic        er, exp_er, ack;
      int          lat;
      for (int a = 0; a < DEPTH; a++) begin
         wd = $urandom;
         apply_stimulus(1'b1, 1'b0, 8'(a), wd, 4'hF, rd, er, lat, ack);
         model_op(1'b1, 1'b0, 8'(a), wd, 4'hF, exp_rd, exp_er);
         tests_run++;
         if (!ack || er !== exp_er || lat != LAT) begin
            tests_failed++;
            $display("[TB] FAIL fill[%0d]: ack=%b err=%b lat=%0d want ack=1 err=%b lat=%0d", a, ack, er, lat, exp_er, LAT);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er, ack;
      int          lat;
      apply_stimulus(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, ack);
      model_op(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || lat != 3) begin tests_failed++; $display("[TB] FAIL store_latency: ack=%b lat=%0d want 3", ack, lat); end
      tests_run++;
      if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_err: got %b want 0", er); end
      tests_run++;
      if (rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL store_rdata_held: got %h want %h", rd, exp_rd); end
      apply_stimulus(1'b0, 1'b0, 8'h10, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h10, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL load_after_store: got %h want DEADBEEF", rd); end
   endtask

   task automatic test_swap();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er, ack;
      int          lat;
      apply_stimulus(1'b1, 1'b0, 8'h20, 32'h5, 4'hF, rd, er, lat, ack);
      model_op(1'b1, 1'b0, 8'h20, 32'h5, 4'hF, exp_rd, exp_er);
      apply_stimulus(1'b0, 1'b1, 8'h20, 32'hA, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b1, 8'h20, 32'hA, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'h5 || lat != LAT) begin tests_failed++; $display("[TB] FAIL swap_old: got %h lat=%0d want 00000005 lat=%0d", rd, lat, LAT); end
      apply_stimulus(1'b0, 1'b0, 8'h20, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h20, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'hA) begin tests_failed++; $display("[TB] FAIL swap_new: got %h want 0000000A", rd); end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er, ack;
      int          lat, acks;
      @(negedge CLK);
      bus.REQ   = 1'b1;
      bus.WE    = 1'b1;
      bus.SWAP  = 1'b0;
      bus.ADDR  = 8'h32;
      bus.WDATA = 32'h12345678;
`ifdef DMEM_BYTE_EN
      bus.BE    = 4'hF;
`endif
      model_op(1'b1, 1'b0, 8'h32, 32'h12345678, 4'hF, exp_rd, exp_er);
      @(posedge CLK);
      @(negedge CLK);
      bus.ADDR  = 8'h30;
      bus.WDATA = 32'hFFFF0000;
      bus.SWAP  = 1'b1;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (i == 0) bus.REQ = 1'b0;
         if (bus.ACK === 1'b1) acks++;
      end
      tests_run++;
      if (acks != 1) begin tests_failed++; $display("[TB] FAIL busy_ack_count: got %0d want 1", acks); end
      apply_stimulus(1'b0, 1'b0, 8'h30, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h30, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL busy_ignored_addr: got %h want %h", rd, exp_rd); end
      apply_stimulus(1'b0, 1'b0, 8'h32, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h32, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL latched_fields: got %h want 12345678", rd); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er, ack;
      int          lat;
      apply_stimulus(1'b0, 1'b0, 8'h10, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h10, 32'h0, 4'hF, exp_rd, exp_er);
      apply_stimulus(1'b1, 1'b0, 8'hC0, 32'hCAFEF00D, 4'hF, rd, er, lat, ack);
      model_op(1'b1, 1'b0, 8'hC0, 32'hCAFEF00D, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || er !== 1'b1 || lat != LAT) begin tests_failed++; $display("[TB] FAIL oor_err: ack=%b err=%b lat=%0d want 1 1 %0d", ack, er, lat, LAT); end
      tests_run++;
      if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL oor_rdata: got %h want 0", rd); end
      @(negedge CLK);
      tests_run++;
      if (bus.ERR !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_err_pulse: got %b want 0", bus.ERR); end
      apply_stimulus(1'b0, 1'b0, 8'h40, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h40, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || er !== 1'b0 || rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL oor_no_alias: got %h err=%b want %h err=0", rd, er, exp_rd); end
      apply_stimulus(1'b0, 1'b0, 8'(DEPTH), 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'(DEPTH), 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL oor_depth_edge: got %h err=%b want 0 err=1", rd, er); end
      apply_stimulus(1'b0, 1'b0, 8'(DEPTH-1), 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'(DEPTH-1), 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || er !== 1'b0 || rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL last_word: got %h err=%b want %h err=0", rd, er, exp_rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er, ack;
      int          lat, acks;
      logic [7:0]  a;
      for (int phase = 0; phase < 2; phase++) begin
         a = (phase == 0) ? 8'h40 : 8'h41;
         @(negedge CLK);
         bus.REQ   = 1'b1;
         bus.WE    = 1'b1;
         bus.SWAP  = 1'b0;
         bus.ADDR  = a;
         bus.WDATA = ~model_mem[a];
`ifdef DMEM_BYTE_EN
         bus.BE    = 4'hF;
`endif
         @(posedge CLK);
         @(negedge CLK);
         bus.REQ = 1'b0;
         if (phase == 1) repeat (WAIT_CYC) @(negedge CLK);
         RST = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         RST = 1'b0;
         model_rdata = 32'h0;
         tests_run++;
         if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid[%0d]: ack=%b busy=%b want 0 0", phase, bus.ACK, bus.BUSY);
         end
         acks = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (bus.ACK === 1'b1) acks++;
         end
         tests_run++;
         if (acks != 0) begin tests_failed++; $display("[TB] FAIL rst_mid_noack[%0d]: got %0d acks want 0", phase, acks); end
         apply_stimulus(1'b0, 1'b0, a, 32'h0, 4'hF, rd, er, lat, ack);
         model_op(1'b0, 1'b0, a, 32'h0, 4'hF, exp_rd, exp_er);
         tests_run++;
         if (!ack || rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL rst_mid_mem[%0d]: got %h want %h", phase, rd, exp_rd); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_rd, rd1, rd2;
      logic        exp_er, busy_after;
      int          cyc, first, second;
      first      = 0;
      second     = 0;
      busy_after = 1'bx;
      rd1        = '0;
      rd2        = '0;
      @(negedge CLK);
      bus.REQ   = 1'b1;
      bus.WE    = 1'b0;
      bus.SWAP  = 1'b0;
      bus.ADDR  = 8'h11;
      bus.WDATA = 32'h0;
      cyc = 0;
      while (second == 0 && cyc < 40) begin
         @(posedge CLK);
         @(negedge CLK);
         cyc++;
         if (first != 0 && cyc == first + 1) busy_after = bus.BUSY;
         if (bus.ACK === 1'b1) begin
            if (first == 0) begin first = cyc; rd1 = bus.RDATA; end
            else begin second = cyc; rd2 = bus.RDATA; bus.REQ = 1'b0; end
         end
      end
      bus.REQ = 1'b0;
      model_op(1'b0, 1'b0, 8'h11, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (first != LAT + 1) begin tests_failed++; $display("[TB] FAIL b2b_first: got cycle %0d want %0d", first, LAT + 1); end
      tests_run++;
      if (second - first != WAIT_CYC + 3) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d want %0d", second - first, WAIT_CYC + 3); end
      tests_run++;
      if (busy_after !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_busy_gap: got %b want 0", busy_after); end
      tests_run++;
      if (rd1 !== exp_rd || rd2 !== exp_rd) begin tests_failed++; $display("[TB] FAIL b2b_rdata: got %h %h want %h", rd1, rd2, exp_rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, exp_rd, wd;
      logic        er, exp_er, ack, we, sw;
      logic [7:0]  a;
      logic [3:0]  be;
      int          lat, op;
      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 2);
         we = (op == 1);
         sw = (op == 2) ? 1'b1 : 1'b0;
         if (op == 2 && $urandom_range(0, 1) == 1) we = 1'b1;
         a  = 8'($urandom_range(0, 159));
         wd = $urandom;
         be = 4'($urandom);
         apply_stimulus(we, sw, a, wd, be, rd, er, lat, ack);
         model_op(we, sw, a, wd, be, exp_rd, exp_er);
         tests_run++;
         if (!ack || lat != LAT || er !== exp_er || rd !== exp_rd) begin
            tests_failed++;
            $display("[TB] FAIL rand[%0d] we=%b sw=%b a=%h: ack=%b lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                     n, we, sw, a, ack, lat, er, rd, LAT, exp_er, exp_rd);
         end
      end
   endtask

`ifdef DMEM_BYTE_EN
   task automatic test_byte_en();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er, ack;
      int          lat;
      apply_stimulus(1'b1, 1'b0, 8'h50, 32'h11223344, 4'hF, rd, er, lat, ack);
      model_op(1'b1, 1'b0, 8'h50, 32'h11223344, 4'hF, exp_rd, exp_er);
      apply_stimulus(1'b1, 1'b0, 8'h50, 32'hAABBCCDD, 4'b0101, rd, er, lat, ack);
      model_op(1'b1, 1'b0, 8'h50, 32'hAABBCCDD, 4'b0101, exp_rd, exp_er);
      apply_stimulus(1'b0, 1'b0, 8'h50, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h50, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'h11BB33DD) begin tests_failed++; $display("[TB] FAIL be_store: got %h want 11BB33DD", rd); end
      apply_stimulus(1'b1, 1'b0, 8'h50, 32'hFFFFFFFF, 4'b0000, rd, er, lat, ack);
      model_op(1'b1, 1'b0, 8'h50, 32'hFFFFFFFF, 4'b0000, exp_rd, exp_er);
      tests_run++;
      if (!ack || lat != LAT) begin tests_failed++; $display("[TB] FAIL be_zero_ack: ack=%b lat=%0d", ack, lat); end
      apply_stimulus(1'b0, 1'b1, 8'h50, 32'h00000000, 4'b1000, rd, er, lat, ack);
      model_op(1'b0, 1'b1, 8'h50, 32'h00000000, 4'b1000, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'h11BB33DD) begin tests_failed++; $display("[TB] FAIL be_swap_old: got %h want 11BB33DD", rd); end
      apply_stimulus(1'b0, 1'b0, 8'h50, 32'h0, 4'hF, rd, er, lat, ack);
      model_op(1'b0, 1'b0, 8'h50, 32'h0, 4'hF, exp_rd, exp_er);
      tests_run++;
      if (!ack || rd !== 32'h00BB33DD) begin tests_failed++; $display("[TB] FAIL be_swap_new: got %h want 00BB33DD", rd); end
   endtask
`endif

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_fill();
      test_store_load();
      test_swap();
      test_busy_ignore();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef DMEM_BYTE_EN
      test_byte_en();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the memory-side end of the load/store/swap request interface driven by the multicycle control FSM.
- Accepts one request at a time, inserts a programmable number of wait states, performs the read, write or atomic swap, then returns a one-cycle ACK with read data.
- Sits between the datapath (address from ALU result, write data from register file) and the word-addressed data storage array.

Parameters:
- DW, 32, data word width in bits.
- AW, 8, address width in bits (word address).
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**AW.
- WAIT_CYC, 2, wait states inserted between request acceptance and the access; 0 to 15.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  1  request strobe; sampled only in IDLE.
- WE  input  1  1 = store, 0 = load; qualified by REQ.
- SWAP  input  1  1 = atomic swap (read old word, write WDATA); overrides WE.
- ADDR  input  AW  word address.
- WDATA  input  DW  store/swap data.
- RDATA  output  DW  load/swap result; valid when ACK=1, held until the next ACK.
- ACK  output  1  one-cycle completion pulse.
- BUSY  output  1  high from the cycle after acceptance through the ACK cycle.
- ERR  output  1  with ACK: address out of range; low otherwise.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RST).
- Reset values: RDATA=0, ACK=0, BUSY=0, ERR=0, FSM=IDLE, wait counter=0. The storage array is not cleared.
- FSM states:
  - IDLE: if REQ=1, latch ADDR, WDATA, WE and SWAP; load the counter with WAIT_CYC; go to WAIT, or to ACCESS if WAIT_CYC=0.
  - WAIT: decrement the counter; go to ACCESS when the counter reaches 1.
  - ACCESS: perform the operation; assert ACK=1 and BUSY=1 for this one cycle; go to IDLE.
  - Decode of the last state value not listed above: go to IDLE with all outputs at reset values.
- Operations in ACCESS:
  - Load: RDATA <= mem[addr].
  - Store: mem[addr] <= WDATA; RDATA unchanged.
  - Swap: RDATA <= old mem[addr] and mem[addr] <= WDATA, both at the same edge (read-before-write).
- Latency: REQ sampled high at edge N gives ACK high during the cycle following edge N+WAIT_CYC+1. With WAIT_CYC=0, ACK appears one cycle after acceptance.
- BUSY goes high the cycle after acceptance and drops with the return to IDLE.
- REQ while BUSY=1 is ignored; it is not queued. The requester must hold REQ until it sees BUSY or ACK.
- REQ high in the ACK cycle is not accepted. The earliest back-to-back acceptance is the cycle after ACK.
- Latched request fields are immune to input changes after acceptance.
- Address >= DEPTH: no write, RDATA <= 0, ERR=1 together with ACK, normal latency.
- Reset mid-operation: the transaction is aborted, memory is unmodified, no ACK is issued, and the FSM returns to IDLE.
- Reset asserted in the ACCESS cycle: reset wins; no write, ACK=0.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- When defined:
  - Adds input port BE (width DW/8).
  - A store or swap writes only the bytes whose BE bit is 1, latched at acceptance.
  - A swap still returns the full old word.
  - BE=0 acts as a write no-op but still ACKs.
- When undefined: no BE port; every write is full-word.

Test Plan:
- Reset, then store: store WDATA=32'hDEADBEEF to ADDR=8'h10 with WAIT_CYC=2 -> ACK exactly 3 cycles after acceptance, ERR=0. A following load of 8'h10 -> RDATA=32'hDEADBEEF.
- Swap: mem[8'h20]=32'h00000005, swap WDATA=32'h0000000A -> RDATA=32'h00000005 on ACK. A following load -> 32'h0000000A.
- Request while busy: second REQ pulsed during WAIT with ADDR=8'h30 -> ignored; only one ACK; mem[8'h30] unchanged.
- Out of range: DEPTH=128, store to ADDR=8'hC0 -> ACK with ERR=1, RDATA=0, no location modified.
- Reset mid-operation: RST during WAIT of a store to 8'h40 -> no ACK, BUSY=0 next cycle, mem[8'h40] keeps its old value.
- Byte enables (DMEM_BYTE_EN defined): mem[8'h50]=32'h11223344, store 32'hAABBCCDD with BE=4'b0101 -> load returns 32'h11BB33DD.
